// File: rtl/serial_sel_sequencer_pkg.sv
// Shared definitions for the serial select sequencer.
// Holds the FSM state encoding, the select-width derivation and the
// first/final select index helpers for both shift directions.
package serial_sel_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_SEL_W = $clog2(DEF_WIDTH);
  localparam int GAP_CNT_W = 4;

  function automatic int sel_w_of(input int width);
    return $clog2(width);
  endfunction

  // Index of the first bit sent for a word.
  function automatic int first_idx(input int width, input bit msb_first);
    return msb_first ? width - 1 : 0;
  endfunction

  // Index of the final bit sent for a word.
  function automatic int final_idx(input int width, input bit msb_first);
    return msb_first ? 0 : width - 1;
  endfunction

endpackage

// File: rtl/serial_sel_sequencer_if.sv
// Load handshake and mux-drive bundle for the serial select sequencer.
// master: upstream/source side (drives load_valid, load_data, hold).
// slave : the sequencer (drives load_ready, word_out, sel_out, bit_valid, bit_out, last).
interface serial_sel_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 3
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             hold;
  logic [WIDTH-1:0] word_out;
  logic [SEL_W-1:0] sel_out;
  logic             bit_valid;
  logic             bit_out;
  logic             last;

  modport master (
    output load_valid, load_data, hold,
    input  load_ready, word_out, sel_out, bit_valid, bit_out, last
  );

  modport slave (
    input  load_valid, load_data, hold,
    output load_ready, word_out, sel_out, bit_valid, bit_out, last
  );
endinterface

// File: rtl/serial_sel_sequencer_sel_counter.sv
// Up/down select counter with synchronous load, enable and terminal flag.
// Ports: clk, rst (async high); load -> cnt=FIRST; en -> step toward FINAL;
// cnt = current index; term = cnt is the final index.
module sel_counter #(
  parameter int               SEL_W = 3,
  parameter logic [SEL_W-1:0] FIRST = '0,
  parameter logic [SEL_W-1:0] FINAL = '1,
  parameter bit               DOWN  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [SEL_W-1:0] cnt,
  output logic             term
);

  logic [SEL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = FIRST;
    end else if (en) begin
      cnt_d = DOWN ? (cnt_q - SEL_W'(1)) : (cnt_q + SEL_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == FINAL);

endmodule

// File: rtl/serial_sel_sequencer.sv
// Serializes a parallel word by holding it on the mux data bus and stepping
// the mux select through every index, one bit slot per cycle.
// Ports: clk, rst (async high), bus (slave modport: load handshake, hold,
// word_out/sel_out mux drive, bit_valid, bit_out reference, last).
module serial_sel_sequencer
  import serial_sel_sequencer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SEL_W     = sel_w_of(WIDTH),
  parameter bit MSB_FIRST = 1'b0,
  parameter int IDLE_GAP  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_sel_sequencer_if.slave  bus
);

  localparam logic [SEL_W-1:0] FIRST_SEL = SEL_W'(first_idx(WIDTH, MSB_FIRST));
  localparam logic [SEL_W-1:0] FINAL_SEL = SEL_W'(final_idx(WIDTH, MSB_FIRST));
  localparam bit               NO_GAP    = (IDLE_GAP == 0);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST =
    GAP_CNT_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     word_q, word_d;
  logic                 bit_valid_q, bit_valid_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;

  logic [SEL_W-1:0]     sel;
  logic                 sel_term;
  logic                 load_ready;
  logic                 accept;
  logic                 cnt_en;

  // Without a gap, the final unstalled slot doubles as a load opportunity so
  // consecutive words stream with no bubble.
  assign load_ready = (state_q == ST_IDLE) ||
                      (NO_GAP && (state_q == ST_SHIFT) && sel_term && !bus.hold);
  assign accept     = bus.load_valid && load_ready;
  // Stop at the final index: wrap-around only ever comes from a fresh load.
  assign cnt_en     = (state_q == ST_SHIFT) && !bus.hold && !sel_term;

  sel_counter #(
    .SEL_W (SEL_W),
    .FIRST (FIRST_SEL),
    .FINAL (FINAL_SEL),
    .DOWN  (MSB_FIRST)
  ) u_sel_counter (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (cnt_en),
    .cnt  (sel),
    .term (sel_term)
  );

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bit_valid_d = bit_valid_q;
    gap_d       = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_SHIFT;
          word_d      = bus.load_data;
          bit_valid_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!bus.hold && sel_term) begin
          if (accept) begin
            word_d = bus.load_data;
          end else if (NO_GAP) begin
            state_d     = ST_IDLE;
            bit_valid_d = 1'b0;
          end else begin
            state_d     = ST_GAP;
            bit_valid_d = 1'b0;
            gap_d       = '0;
          end
        end
      end
      ST_GAP: begin
        // hold is deliberately ignored while spacing words apart.
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_CNT_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        bit_valid_d = 1'b0;
        gap_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      bit_valid_q <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bit_valid_q <= bit_valid_d;
      gap_q       <= gap_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.word_out   = word_q;
  assign bus.sel_out    = sel;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.bit_out    = word_q[sel];
  assign bus.last       = bit_valid_q && sel_term;

endmodule

// File: tb/tb_serial_sel_sequencer.sv
module tb_serial_sel_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  serial_sel_sequencer_if #(.WIDTH(8), .SEL_W(3)) if0 ();
  serial_sel_sequencer_if #(.WIDTH(8), .SEL_W(3)) if1 ();
  serial_sel_sequencer_if #(.WIDTH(8), .SEL_W(3)) if2 ();

  serial_sel_sequencer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0), .IDLE_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  serial_sel_sequencer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b1), .IDLE_GAP(0)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));
  serial_sel_sequencer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0), .IDLE_GAP(2)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave));

  // Hand-derived bit sequences, slot 0 leftmost.
  logic [0:7] t1_bits   = 8'b0100_1010;  // 8'd82 LSB first
  logic [0:7] t2_bits   = 8'b0101_0010;  // 8'd82 MSB first
  logic [0:7] t5b_bits  = 8'b0000_1111;  // 8'hF0 LSB first
  logic [0:7] t6_bits   = 8'b1100_0011;  // 8'hC3 LSB first
  logic [2:0] t3_sel [11] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic       t3_hold[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       t3_bit [11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    if0.load_valid = 1'b0; if0.load_data = '0; if0.hold = 1'b0;
    if1.load_valid = 1'b0; if1.load_data = '0; if1.hold = 1'b0;
    if2.load_valid = 1'b0; if2.load_data = '0; if2.hold = 1'b0;

    // Reset state
    tick;
    tick;
    chk("rst word_out", if0.word_out, 0);
    chk("rst sel_out", if0.sel_out, 0);
    chk("rst bit_valid", if0.bit_valid, 0);
    chk("rst last", if0.last, 0);
    chk("rst load_ready", if0.load_ready, 1);
    chk("rst sel_out msb", if1.sel_out, 0);
    rst = 1'b0;
    tick;
    if0.hold = 1'b1;  // hold in IDLE must not block a load
    settle;
    chk("idle hold ready", if0.load_ready, 1);
    if0.hold = 1'b0;

    // Test 1: LSB first, 8'd82
    if0.load_valid = 1'b1; if0.load_data = 8'd82;
    settle;
    chk("t1 accept ready", if0.load_ready, 1);
    tick;
    if0.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle;
      chk($sformatf("t1 sel %0d", i), if0.sel_out, i);
      chk($sformatf("t1 bit %0d", i), if0.bit_out, t1_bits[i]);
      chk($sformatf("t1 valid %0d", i), if0.bit_valid, 1);
      chk($sformatf("t1 last %0d", i), if0.last, (i == 7));
      chk($sformatf("t1 ready %0d", i), if0.load_ready, (i == 7));
      tick;
    end
    chk("t1 end valid", if0.bit_valid, 0);
    chk("t1 end sel", if0.sel_out, 7);
    chk("t1 end last", if0.last, 0);
    chk("t1 end ready", if0.load_ready, 1);

    // Test 2: MSB first, 8'd82
    if1.load_valid = 1'b1; if1.load_data = 8'd82;
    tick;
    if1.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle;
      chk($sformatf("t2 sel %0d", i), if1.sel_out, 7 - i);
      chk($sformatf("t2 bit %0d", i), if1.bit_out, t2_bits[i]);
      chk($sformatf("t2 last %0d", i), if1.last, (i == 7));
      chk($sformatf("t2 ready %0d", i), if1.load_ready, (i == 7));
      tick;
    end
    chk("t2 end valid", if1.bit_valid, 0);
    chk("t2 end sel", if1.sel_out, 0);

    // Test 3: hold for 3 cycles at sel=3, 8'hA5
    if0.load_valid = 1'b1; if0.load_data = 8'hA5;
    tick;
    if0.load_valid = 1'b0;
    for (int k = 0; k < 11; k++) begin
      if0.hold = t3_hold[k];
      settle;
      chk($sformatf("t3 sel %0d", k), if0.sel_out, t3_sel[k]);
      chk($sformatf("t3 bit %0d", k), if0.bit_out, t3_bit[k]);
      chk($sformatf("t3 valid %0d", k), if0.bit_valid, 1);
      chk($sformatf("t3 word %0d", k), if0.word_out, 8'hA5);
      chk($sformatf("t3 last %0d", k), if0.last, (k == 10));
      chk($sformatf("t3 ready %0d", k), if0.load_ready, (k == 10));
      tick;
    end
    if0.hold = 1'b0;
    chk("t3 end valid", if0.bit_valid, 0);

    // Test 3b: hold in the last slot keeps last high and ready low
    if0.load_valid = 1'b1; if0.load_data = 8'h80;
    tick;
    if0.load_valid = 1'b0;
    repeat (7) tick;
    if0.hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle;
      chk($sformatf("t3b last %0d", k), if0.last, 1);
      chk($sformatf("t3b ready %0d", k), if0.load_ready, 0);
      chk($sformatf("t3b bit %0d", k), if0.bit_out, 1);
      tick;
    end
    if0.hold = 1'b0;
    settle;
    chk("t3b release ready", if0.load_ready, 1);
    tick;
    chk("t3b end valid", if0.bit_valid, 0);

    // Test 4: back-to-back 8'hFF then 8'h00, no bubble
    if0.load_valid = 1'b1; if0.load_data = 8'hFF;
    tick;
    if0.load_data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) if0.load_valid = 1'b0;
      settle;
      chk($sformatf("t4 valid %0d", i), if0.bit_valid, 1);
      chk($sformatf("t4 sel %0d", i), if0.sel_out, i % 8);
      chk($sformatf("t4 bit %0d", i), if0.bit_out, (i < 8));
      chk($sformatf("t4 ready %0d", i), if0.load_ready, ((i % 8) == 7));
      tick;
    end
    chk("t4 end valid", if0.bit_valid, 0);

    // Test 5: IDLE_GAP=2, 8'h0F then 8'hF0 offered back-to-back
    if2.load_valid = 1'b1; if2.load_data = 8'h0F;
    tick;
    if2.load_data = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      settle;
      chk($sformatf("t5a sel %0d", i), if2.sel_out, i);
      chk($sformatf("t5a bit %0d", i), if2.bit_out, (i < 4));
      chk($sformatf("t5a last %0d", i), if2.last, (i == 7));
      chk($sformatf("t5a ready %0d", i), if2.load_ready, 0);
      tick;
    end
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("t5 gap valid %0d", g), if2.bit_valid, 0);
      chk($sformatf("t5 gap ready %0d", g), if2.load_ready, 0);
      tick;
    end
    chk("t5 idle valid", if2.bit_valid, 0);
    chk("t5 idle ready", if2.load_ready, 1);
    tick;
    if2.load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle;
      chk($sformatf("t5b valid %0d", i), if2.bit_valid, 1);
      chk($sformatf("t5b sel %0d", i), if2.sel_out, i);
      chk($sformatf("t5b bit %0d", i), if2.bit_out, t5b_bits[i]);
      tick;
    end
    chk("t5b gap valid", if2.bit_valid, 0);
    chk("t5b gap ready", if2.load_ready, 0);

    // Test 6: async reset mid-word at sel=5 of 8'hC3
    if0.load_valid = 1'b1; if0.load_data = 8'hC3;
    tick;
    if0.load_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      settle;
      chk($sformatf("t6 sel %0d", i), if0.sel_out, i);
      chk($sformatf("t6 bit %0d", i), if0.bit_out, t6_bits[i]);
      if (i < 5) tick;
    end
    #1 rst = 1'b1;
    #1;
    chk("t6 rst valid", if0.bit_valid, 0);
    chk("t6 rst word", if0.word_out, 0);
    chk("t6 rst sel", if0.sel_out, 0);
    chk("t6 rst last", if0.last, 0);
    chk("t6 rst ready", if0.load_ready, 1);
    rst = 1'b0;
    tick;
    chk("t6 post valid", if0.bit_valid, 0);
    if0.load_valid = 1'b1; if0.load_data = 8'h81;
    tick;
    if0.load_valid = 1'b0;
    settle;
    chk("t6 reload sel", if0.sel_out, 0);
    chk("t6 reload valid", if0.bit_valid, 1);
    chk("t6 reload bit", if0.bit_out, 1);
    chk("t6 reload word", if0.word_out, 8'h81);
    repeat (8) tick;
    chk("t6 drain valid", if0.bit_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_sel_sequencer.md
Name: serial_sel_sequencer

Overview:
Upstream driver for the 8:1 bit-select mux stage. It accepts a parallel word over a valid/ready handshake, holds it on the mux data bus and steps the 3-bit select through every index, so the word leaves as one bit per cycle. It also generates the bit-valid, last-bit and stall signals, and provides a local copy of the selected bit so downstream logic can check it.

Parameters:
WIDTH, 8, word width; must be a power of 2 and at least 2
SEL_W, 3, select width; equals log2(WIDTH)
MSB_FIRST, 0, 0 = send index 0 first and count up; 1 = send index WIDTH-1 first and count down
IDLE_GAP, 0, number of idle cycles inserted after each word (0..15)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
load_valid  in  1  a word is offered on load_data
load_data  in  WIDTH  word to serialize
load_ready  out  1  sequencer can accept a word this cycle
hold  in  1  downstream stall; freezes sequencing
word_out  out  WIDTH  held word; drives the mux data bus
sel_out  out  SEL_W  select index; drives the mux select
bit_valid  out  1  sel_out/word_out are a valid bit slot
bit_out  out  1  word_out[sel_out], local reference copy
last  out  1  the current slot is the final bit of the word

Behaviour:
- Reset (async, active-high): state IDLE, word_out=0, sel_out=0, bit_valid=0, last=0, gap counter=0. load_ready=1 because the state is IDLE. No output glitches past the reset edge.
- FSM states: IDLE, SHIFT, GAP.
- Handshake: a word is accepted on a posedge where load_valid and load_ready are both 1. If load_valid is high while load_ready is low, the word is ignored; the upstream must hold it.
- On accept:
  - word_out<=load_data.
  - sel_out<=0, or WIDTH-1 when MSB_FIRST=1.
  - state<=SHIFT.
  - bit_valid=1 from the next cycle (accept-to-first-bit latency is 1 cycle).
- SHIFT:
  - Each cycle with hold=0, sel_out advances by +1 (or -1 when MSB_FIRST=1).
  - With hold=1, sel_out, word_out and bit_valid are frozen.
  - bit_out is combinational from the registered word_out and sel_out.
- last=1 exactly when bit_valid=1 and sel_out is the final index (WIDTH-1, or 0 when MSB_FIRST=1).
- Last slot with hold=0:
  - IDLE_GAP=0: load_ready=1 in the same cycle, so a back-to-back accept reloads directly into SHIFT with no bubble (WIDTH cycles per word). Without an accept, go to IDLE with bit_valid=0 and sel_out unchanged.
  - IDLE_GAP>0: go to GAP with load_ready=0.
- GAP: counts IDLE_GAP cycles with bit_valid=0, then goes to IDLE. hold is ignored in GAP.
- Select index never wraps within a word: index WIDTH-1 to 0 (or the reverse) only happens through a fresh accept.
- hold=1 in the last slot: last stays 1, load_ready stays 0 (IDLE_GAP=0 case) until hold drops.
- hold in IDLE has no effect.
- Reset mid-word: the word is abandoned immediately and is not resumed.
- Arithmetic: sel_out is an SEL_W-bit register. The gap counter is 4 bits and compares against IDLE_GAP-1.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, SHIFT=2'd1, GAP=2'd2
  - the SEL_W derivation constant
  - the first and final index constants for each direction
- One sub-module, sel_counter: an up/down select counter with load, enable and terminal flag. The top level keeps the FSM, handshake and word register.
- bit_out is a plain indexed read; no extra mux instance is needed.

Test Plan:
1. Reset release, load 8'd82 (0101_0010) with LSB first and hold=0 → sel_out 0..7 on consecutive cycles, bit_out=0,1,0,0,1,0,1,0, last only at sel=7, load_ready=0 during slots 0..6.
2. MSB_FIRST=1, load 8'd82 → sel_out 7..0, bit_out=0,1,0,1,0,0,1,0, last at sel=0.
3. hold=1 for 3 cycles at sel=3 with 8'hA5 loaded → sel_out stays 3, bit_out stays 0 and bit_valid stays 1 for 3 cycles, then sel_out resumes at 4. Total word length is 11 cycles.
4. Back-to-back 8'hFF then 8'h00, load_valid continuously high, IDLE_GAP=0 → 16 contiguous bit_valid cycles, eight 1s then eight 0s, with load_ready high only on the last-slot cycles.
5. IDLE_GAP=2, two words offered back-to-back → exactly 2 cycles of bit_valid=0 with load_ready=0 between the words, then 1 IDLE cycle before the second accept.
6. Assert rst asynchronously (between clock edges) at sel=5 of 8'hC3 → bit_valid, word_out and sel_out read 0 immediately. load_ready=1 and the next accept starts from sel=0.
